memory_access_controller: RTL and testbench
===========================================

Name: memory_access_controller

Overview:
- Sequencer directly upstream of the 8x8 NAND-latch memory unit.
- Accepts single read/write requests over a valid/ready handshake, then drives the unit's op/sel/address/in_bus pins in a fixed setup -> strobe -> hold pattern so latch data and address are stable around the sel pulse.
- Captures out_bus on reads and returns one response per request.
- Only one request is in flight at a time; the unit's latches are never strobed with changing inputs.

Parameters:
- DATA_W, 8, data bus width (matches memory in_bus/out_bus).
- ADDR_W, 3, word address width (8 words).
- SETUP_CYC, 1, cycles op/address/in_bus are stable with sel=0 before the strobe; must be >=1.
- STROBE_CYC, 2, cycles sel is held high; must be >=1.
- HOLD_CYC, 1, cycles op/address/in_bus are held with sel=0 after the strobe; must be >=1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target word.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- mem_op  output  1  to memory op (1 = write, 0 = read).
- mem_sel  output  1  to memory sel (strobe).
- mem_address  output  ADDR_W  to memory address.
- mem_in_bus  output  DATA_W  to memory in_bus.
- mem_out_bus  input  DATA_W  from memory out_bus.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - State goes to IDLE.
  - Counter goes to 0.
  - Outputs: req_ready=0 in the reset cycle and 1 from the first post-reset cycle; rsp_valid=0; rsp_rdata=0; mem_op=0; mem_sel=0; mem_address=0; mem_in_bus=0.
- All outputs are registered. No combinational path exists from any input to any output.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready=1; mem_sel=0.
  - When req_valid && req_ready at an edge: latch req_write/req_addr/req_wdata into mem_op/mem_address/mem_in_bus. For a read, mem_in_bus=0. Load counter with SETUP_CYC-1. Go to SETUP; req_ready falls on the same edge.
- SETUP:
  - mem_sel=0, pins stable.
  - When counter==0: load STROBE_CYC-1, set mem_sel=1, go to STROBE. Otherwise decrement.
- STROBE:
  - mem_sel=1, pins stable.
  - On the edge where counter==0: clear mem_sel, load HOLD_CYC-1, go to HOLD. If the request is a read, also register mem_out_bus into an internal read register on this same edge.
- HOLD:
  - mem_sel=0, pins stable.
  - When counter==0: go to RESP with rsp_valid=1 and rsp_rdata = read register (read) or 0 (write).
- RESP:
  - rsp_valid high for exactly one cycle.
  - Next edge: rsp_valid=0, req_ready=1, go to IDLE. mem_op/mem_address/mem_in_bus keep their last values; only mem_sel is guaranteed low.
- Latency, accept edge to rsp_valid-rising edge: SETUP_CYC+STROBE_CYC+HOLD_CYC edges (4 with defaults).
- Minimum request spacing: SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles (6 with defaults).
- req_valid while req_ready=0: ignored. The requester must hold the request; nothing is queued or lost.
- Request fields changing after acceptance have no effect; the latched copy drives the pins.
- mem_op, mem_address and mem_in_bus never change while mem_sel=1, or in the cycles adjacent to the high-sel window.
- Reset mid-operation, any state: the next edge forces mem_sel=0 and the IDLE outputs. The request is dropped with no rsp_valid. The memory contents are whatever the latches hold; the controller does not clear memory.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - OP_WRITE=1, OP_READ=0;
  - default DATA_W/ADDR_W;
  - counter width = clog2 of the maximum phase parameter.
- Sub-module phase_counter: loadable down-counter with a zero flag, reused for all three timed phases.
- The FSM and pin registers stay in the top.

Test Plan:
- Reset then idle: assert rst 2 cycles -> all mem_* = 0, rsp_valid=0; req_ready=1 one cycle after rst drops.
- Write: req_write=1, addr=3'b000, wdata=8'b01010101, defaults -> mem_op=1, addr 000 and in_bus 01010101 stable 1 cycle before sel; sel high exactly 2 cycles; rsp_valid 4 edges after accept with rsp_rdata=0.
- Readback: read addr 000 after that write -> mem_op=0, sel pulse of 2 cycles, rsp_rdata=8'b01010101. Then write 8'hA3 to addr 7, read addr 7 -> 8'hA3, and addr 0 still reads 8'h55.
- Back-pressure: hold req_valid=1 continuously with two different requests -> second is accepted only when req_ready returns; accepts are 6 cycles apart; pins never change while sel=1.
- Reset mid-strobe: assert rst while mem_sel=1 -> mem_sel=0 on the next edge, no rsp_valid, next request completes normally.
- Parameter sweep: SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 -> sel width 1, latency 6 edges, same data correctness.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the NAND-latch memory access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 3;
  localparam int unsigned DEF_SETUP_CYC  = 1;
  localparam int unsigned DEF_STROBE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC   = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter only ever holds phase_len-1, so clog2 of the longest phase suffices.
  function automatic int unsigned cnt_width(input int unsigned max_phase);
    return (max_phase < 2) ? 1 : $clog2(max_phase);
  endfunction

  localparam int unsigned DEF_CNT_W =
    cnt_width(max3(DEF_SETUP_CYC, DEF_STROBE_CYC, DEF_HOLD_CYC));

endpackage

// File: rtl/memory_access_controller_phase_counter.sv
// Loadable down-counter with zero flag, shared by the setup, strobe and hold phases.
module phase_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/memory_access_controller.sv
// Single-request sequencer driving the 8x8 latch memory with a setup/strobe/hold pin pattern.
module memory_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_op,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus
);

  localparam int unsigned CNT_W = cnt_width(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC));
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t            state;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic [DATA_W-1:0] rd_data;

  phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Counter reloads on exactly the edges where the FSM enters a timed phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = STROBE_LD;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_op      <= OP_READ;
      mem_sel     <= 1'b0;
      mem_address <= '0;
      mem_in_bus  <= '0;
      rd_data     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_sel <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            mem_op      <= req_write;
            mem_address <= req_addr;
            mem_in_bus  <= req_write ? req_wdata : '0;
            state       <= SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            mem_sel <= 1'b1;
            state   <= STROBE;
          end
        end
        STROBE: begin
          if (cnt_zero) begin
            mem_sel <= 1'b0;
            if (mem_op == OP_READ) begin
              rd_data <= mem_out_bus;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (mem_op == OP_READ) ? rd_data : '0;
            state     <= RESP;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_sel <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench: default-timing controller plus a (3,1,2) timing variant, each with a latch-memory model.
module tb_memory_access_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;

  logic       m1_ready, m1_rsp, m1_op, m1_sel;
  logic [7:0] m1_rdata, m1_in, m1_out;
  logic [2:0] m1_addr;
  logic       m2_ready, m2_rsp, m2_op, m2_sel;
  logic [7:0] m2_rdata, m2_in, m2_out;
  logic [2:0] m2_addr;

  logic [7:0] mem1 [8];
  logic [7:0] mem2 [8];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic       c_ready, c_rsp, c_op, c_sel;
  logic [7:0] c_rdata, c_in;
  logic [2:0] c_addr;

  always #5 clk = ~clk;

  memory_access_controller u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(m1_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(m1_rsp), .rsp_rdata(m1_rdata), .mem_op(m1_op), .mem_sel(m1_sel),
    .mem_address(m1_addr), .mem_in_bus(m1_in), .mem_out_bus(m1_out)
  );

  memory_access_controller #(
    .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(m2_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(m2_rsp), .rsp_rdata(m2_rdata), .mem_op(m2_op), .mem_sel(m2_sel),
    .mem_address(m2_addr), .mem_in_bus(m2_in), .mem_out_bus(m2_out)
  );

  // Latch memory model: transparent write while sel&op, combinational read port.
  always @(posedge clk) begin
    if (m1_sel && m1_op) mem1[m1_addr] <= m1_in;
    if (m2_sel && m2_op) mem2[m2_addr] <= m2_in;
  end
  assign m1_out = mem1[m1_addr];
  assign m2_out = mem2[m2_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input bit which);
    if (which) begin
      c_ready = m2_ready; c_rsp = m2_rsp; c_rdata = m2_rdata; c_op = m2_op;
      c_sel = m2_sel; c_addr = m2_addr; c_in = m2_in;
    end else begin
      c_ready = m1_ready; c_rsp = m1_rsp; c_rdata = m1_rdata; c_op = m1_op;
      c_sel = m1_sel; c_addr = m1_addr; c_in = m1_in;
    end
  endtask

  task automatic wait_ready(input bit which);
    int unsigned n;
    n = 0;
    snap(which);
    while (!c_ready && n < 50) begin
      step();
      n++;
      snap(which);
    end
    checks++;
    if (c_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready dut%0d: req_ready=%b after %0d cycles, required 1", which + 1, c_ready, n);
    end
  endtask

  task automatic run_req(input bit which, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd,
                         input int unsigned s_e, input int unsigned t_e,
                         input int unsigned h_e);
    int unsigned lat, setup, strobe, hold;
    bit seen, pinerr;
    logic [7:0] exp_in;
    exp_in = w ? d : 8'h00;
    wait_ready(which);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    snap(which);
    checks++;
    if (c_ready !== 1'b0 || c_sel !== 1'b0) begin
      errors++;
      $display("FAIL accept_state dut%0d: ready=%b sel=%b, required 0 0", which + 1, c_ready, c_sel);
    end
    checks++;
    if (c_op !== w || c_addr !== a || c_in !== exp_in) begin
      errors++;
      $display("FAIL latched_pins dut%0d: op=%b addr=%h in=%h, required %b %h %h",
               which + 1, c_op, c_addr, c_in, w, a, exp_in);
    end
    lat = 0; setup = 1; strobe = 0; hold = 0; seen = 0; pinerr = 0;
    while (!c_rsp && lat < 40) begin
      step();
      lat++;
      snap(which);
      if (c_op !== w || c_addr !== a || c_in !== exp_in) pinerr = 1;
      if (c_sel) begin
        seen = 1;
        strobe++;
      end else if (!c_rsp) begin
        if (seen) hold++;
        else setup++;
      end
    end
    checks++;
    if (lat != s_e + t_e + h_e) begin
      errors++;
      $display("FAIL latency dut%0d: %0d edges, required %0d", which + 1, lat, s_e + t_e + h_e);
    end
    checks++;
    if (setup != s_e || strobe != t_e || hold != h_e) begin
      errors++;
      $display("FAIL phase_widths dut%0d: setup=%0d sel=%0d hold=%0d, required %0d %0d %0d",
               which + 1, setup, strobe, hold, s_e, t_e, h_e);
    end
    checks++;
    if (pinerr) begin
      errors++;
      $display("FAIL pin_stability dut%0d: pins moved during operation, required stable", which + 1);
    end
    checks++;
    if (c_rdata !== exp_rd) begin
      errors++;
      $display("FAIL rsp_rdata dut%0d addr %0d: got %h, required %h", which + 1, a, c_rdata, exp_rd);
    end
    step();
    snap(which);
    checks++;
    if (c_rsp !== 1'b0 || c_ready !== 1'b1 || c_sel !== 1'b0) begin
      errors++;
      $display("FAIL resp_return dut%0d: rsp=%b ready=%b sel=%b, required 0 1 0",
               which + 1, c_rsp, c_ready, c_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({m1_ready, m1_rsp, m1_rdata, m1_op, m1_sel, m1_addr, m1_in} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h op=%b sel=%b addr=%h in=%h, required all 0",
               m1_ready, m1_rsp, m1_rdata, m1_op, m1_sel, m1_addr, m1_in);
    end
    checks++;
    if (m2_ready !== 1'b0 || m2_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: ready=%b sel=%b, required 0 0", m2_ready, m2_sel);
    end
    rst = 1'b0;
    step();
    checks++;
    if (m1_ready !== 1'b1 || m2_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: dut1=%b dut2=%b, required 1 1", m1_ready, m2_ready);
    end
  endtask

  task automatic test_write();
    run_req(1'b0, 1'b1, 3'd0, 8'b01010101, 8'h00, 1, 2, 1);
  endtask

  task automatic test_readback();
    run_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h55, 1, 2, 1);
    run_req(1'b0, 1'b1, 3'd7, 8'hA3, 8'h00, 1, 2, 1);
    run_req(1'b0, 1'b0, 3'd7, 8'h00, 8'hA3, 1, 2, 1);
    run_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h55, 1, 2, 1);
  endtask

  task automatic test_back_to_back();
    int unsigned spacing, n;
    bit accepted, pinerr, prev;
    wait_ready(1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'h3C;
    step();
    req_write = 1'b0; req_addr = 3'd5; req_wdata = 8'hFF;
    spacing = 0; accepted = 0; pinerr = 0;
    while (!accepted && spacing < 20) begin
      prev = m1_ready;
      step();
      spacing++;
      if (prev && req_valid) accepted = 1;
      else if (m1_sel && (m1_op !== 1'b1 || m1_addr !== 3'd5 || m1_in !== 8'h3C)) pinerr = 1;
    end
    req_valid = 1'b0;
    checks++;
    if (!accepted || spacing != 6) begin
      errors++;
      $display("FAIL accept_spacing: accepted=%0d spacing=%0d, required 1 6", accepted, spacing);
    end
    checks++;
    if (pinerr) begin
      errors++;
      $display("FAIL b2b_pins: pins changed while sel high, required stable");
    end
    checks++;
    if (m1_op !== 1'b0 || m1_addr !== 3'd5 || m1_in !== 8'h00) begin
      errors++;
      $display("FAIL second_latch: op=%b addr=%h in=%h, required 0 5 00", m1_op, m1_addr, m1_in);
    end
    n = 0;
    while (!m1_rsp && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (m1_rsp !== 1'b1 || m1_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_read: rsp=%b rdata=%h, required 1 3c", m1_rsp, m1_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_strobe();
    bit rsp_seen;
    wait_ready(1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'hF0;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (m1_sel !== 1'b1) begin
      errors++;
      $display("FAIL strobe_precondition: sel=%b, required 1", m1_sel);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({m1_sel, m1_rsp, m1_ready, m1_op, m1_addr, m1_in} !== '0) begin
      errors++;
      $display("FAIL mid_reset: sel=%b rsp=%b ready=%b op=%b addr=%h in=%h, required all 0",
               m1_sel, m1_rsp, m1_ready, m1_op, m1_addr, m1_in);
    end
    rst = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m1_rsp) rsp_seen = 1;
    end
    checks++;
    if (rsp_seen || m1_ready !== 1'b1) begin
      errors++;
      $display("FAIL dropped_request: rsp_seen=%0d ready=%b, required 0 1", rsp_seen, m1_ready);
    end
    run_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h55, 1, 2, 1);
  endtask

  task automatic test_param_sweep();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    run_req(1'b1, 1'b1, 3'd2, 8'h5A, 8'h00, 3, 1, 2);
    run_req(1'b1, 1'b0, 3'd2, 8'h00, 8'h5A, 3, 1, 2);
    run_req(1'b1, 1'b1, 3'd6, 8'hC3, 8'h00, 3, 1, 2);
    run_req(1'b1, 1'b0, 3'd6, 8'h00, 8'hC3, 3, 1, 2);
    run_req(1'b1, 1'b0, 3'd2, 8'h00, 8'h5A, 3, 1, 2);
  endtask

  initial begin
    foreach (mem1[i]) mem1[i] = 8'h00;
    foreach (mem2[i]) mem2[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_write();
    test_readback();
    test_back_to_back();
    test_reset_mid_strobe();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
